// File: rtl/seq_detect_prog.sv
// Programmable serial pattern detector.
// Bits qualified by in_valid shift into a history register. A match is
// declared when enough bits have been collected and the low len bits of
// {history, in} equal the active pattern. The match flag is registered, so it
// appears one cycle after the sampling edge. A saturating counter tallies
// matches. Configuration loads with an out-of-range length are rejected
// and flagged with a one-cycle cfg_err pulse.
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  logic [MAX_LEN-1:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [MAX_LEN-1:0] r_pat;
  logic [LEN_W-1:0]   r_len;
  logic               r_ovl;
  logic               r_out;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;

  logic               w_len_ok;
  logic               w_load_ok;
  logic               w_load_bad;
  logic               w_shift;
  logic [MAX_LEN:0]   w_cat;
  logic [MAX_LEN:0]   w_mask;
  logic               w_fill_ok;
  logic               w_eq;
  logic               w_match;
  logic [LEN_W-1:0]   w_fill_nxt;

  assign w_len_ok   = (cfg_len >= LEN_W'(2)) && (cfg_len <= LEN_W'(MAX_LEN));
  assign w_load_ok  = cfg_load && w_len_ok;
  assign w_load_bad = cfg_load && !w_len_ok;
  // A rejected load leaves the data path running normally.
  assign w_shift    = in_valid && !w_load_ok;

  // Candidate window: history with the incoming bit appended. Bit MAX_LEN can
  // never be selected because r_len never exceeds MAX_LEN.
  assign w_cat = {r_hist, in};

  // Select the low r_len bits of the window for comparison.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i <= MAX_LEN; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
  end

  // r_len is always >= 2, so r_len-1 cannot underflow.
  assign w_fill_ok = (r_fill >= (r_len - LEN_W'(1)));
  assign w_eq      = ((w_cat & w_mask) == ({1'b0, r_pat} & w_mask));
  assign w_match   = w_shift && w_fill_ok && w_eq;

  // Fill saturates at len; a non-overlapping match restarts collection.
  always_comb begin
    w_fill_nxt = r_fill;
    if (w_match && !r_ovl) begin
      w_fill_nxt = '0;
    end else if (r_fill < r_len) begin
      w_fill_nxt = r_fill + LEN_W'(1);
    end
  end

  // Active configuration: defaults on reset, replaced only by a legal load.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pat <= MAX_LEN'(4'b1101);
      r_len <= LEN_W'(4);
      r_ovl <= 1'b1;
    end else if (w_load_ok) begin
      r_pat <= cfg_pattern;
      r_len <= cfg_len;
      r_ovl <= cfg_overlap;
    end
  end

  // History, fill, match flag and counter; a legal load clears all of them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hist <= '0;
      r_fill <= '0;
      r_out  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_load_ok) begin
      r_hist <= '0;
      r_fill <= '0;
      r_out  <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_out <= w_match;
      if (w_shift) begin
        r_hist <= w_cat[MAX_LEN-1:0];
        r_fill <= w_fill_nxt;
      end
      if (w_match && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // One-cycle pulse for each rejected load request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_load_bad;
    end
  end

  assign out         = r_out;
  assign match_count = r_cnt;
  assign cfg_err     = r_err;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Bench for seq_detect_prog: a vector table with hand-computed expectations,
// plus hand-written reset/reload sequences. Expected outputs are queued when a
// vector is driven and popped when the registered result is sampled.
module tb_seq_detect_prog;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 5;
  localparam int CNT_W   = 2;

  logic               clk;
  logic               reset;
  logic               in;
  logic               in_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               out;
  logic [CNT_W-1:0]   match_count;
  logic               cfg_err;

  seq_detect_prog #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in         (in),
    .in_valid   (in_valid),
    .cfg_load   (cfg_load),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_overlap(cfg_overlap),
    .out        (out),
    .match_count(match_count),
    .cfg_err    (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic               vld;
    logic               b;
    logic               ld;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic               ovl;
    logic               eo;
    logic [CNT_W-1:0]   ec;
    logic               ee;
    string              tag;
  } vec_t;

  typedef struct {
    logic             eo;
    logic [CNT_W-1:0] ec;
    logic             ee;
    string            tag;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, req);
    end
  endtask

  function automatic void add(input logic vld, input logic b, input logic ld,
                              input logic [MAX_LEN-1:0] pat, input logic [LEN_W-1:0] len,
                              input logic ovl, input logic eo, input logic [CNT_W-1:0] ec,
                              input logic ee, input string tag);
    vec_t v;
    v.vld = vld; v.b = b; v.ld = ld; v.pat = pat; v.len = len; v.ovl = ovl;
    v.eo = eo; v.ec = ec; v.ee = ee; v.tag = tag;
    vecs.push_back(v);
  endfunction

  // Plain data bit (or gap) with no load request.
  function automatic void bit_(input logic vld, input logic b, input logic eo,
                               input logic [CNT_W-1:0] ec, input string tag);
    add(vld, b, 1'b0, '0, '0, 1'b0, eo, ec, 1'b0, tag);
  endfunction

  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    in_valid    = v.vld;
    in          = v.b;
    cfg_load    = v.ld;
    cfg_pattern = v.pat;
    cfg_len     = v.len;
    cfg_overlap = v.ovl;
    exp_q.push_back('{v.eo, v.ec, v.ee, v.tag});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, " out"}, int'(out), int'(e.eo));
    chk({e.tag, " count"}, int'(match_count), int'(e.ec));
    chk({e.tag, " cfg_err"}, int'(cfg_err), int'(e.ee));
  endtask

  task automatic hbit(input logic vld, input logic b, input logic eo,
                      input logic [CNT_W-1:0] ec, input string tag);
    vec_t v;
    v.vld = vld; v.b = b; v.ld = 1'b0; v.pat = '0; v.len = '0; v.ovl = 1'b0;
    v.eo = eo; v.ec = ec; v.ee = 1'b0; v.tag = tag;
    step(v);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, " out"}, int'(out), 0);
    chk({tag, " count"}, int'(match_count), 0);
    chk({tag, " cfg_err"}, int'(cfg_err), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;

    // Defaults, overlapping 1101: matches after bits 4 and 7.
    bit_(1, 1, 0, 0, "def b1");
    bit_(1, 1, 0, 0, "def b2");
    bit_(1, 0, 0, 0, "def b3");
    bit_(1, 1, 1, 1, "def b4");
    bit_(1, 1, 0, 1, "def b5");
    bit_(1, 0, 0, 1, "def b6");
    bit_(1, 1, 1, 2, "def b7");
    bit_(0, 1, 0, 2, "def idle");
    // Illegal loads: rejected, config and state kept, in_valid still honoured.
    add(0, 0, 1, 8'h03, 5'd0, 0, 0, 2, 1, "bad len0");
    bit_(0, 0, 0, 2, "bad gap");
    add(1, 1, 1, 8'h03, 5'd9, 0, 0, 2, 1, "bad len9");
    bit_(1, 1, 0, 2, "bad b1");
    bit_(1, 0, 0, 2, "bad b0");
    bit_(1, 1, 1, 3, "bad b1 match");
    bit_(1, 1, 0, 3, "bad after");
    // Non-overlapping 1101: only one match; in_valid on the load edge discarded.
    add(1, 1, 1, 8'b0000_1101, 5'd4, 0, 0, 0, 0, "nov load");
    bit_(1, 1, 0, 0, "nov b1");
    bit_(1, 1, 0, 0, "nov b2");
    bit_(1, 0, 0, 0, "nov b3");
    bit_(1, 1, 1, 1, "nov b4");
    bit_(1, 1, 0, 1, "nov b5");
    bit_(1, 0, 0, 1, "nov b6");
    bit_(1, 1, 0, 1, "nov b7");
    // in_valid gaps do not break a sequence; in toggles during the gap.
    add(0, 0, 1, 8'b0000_1101, 5'd4, 1, 0, 0, 0, "gap load");
    bit_(1, 1, 0, 0, "gap b1");
    bit_(1, 1, 0, 0, "gap b2");
    bit_(0, 0, 0, 0, "gap g1");
    bit_(0, 1, 0, 0, "gap g2");
    bit_(0, 0, 0, 0, "gap g3");
    bit_(1, 0, 0, 0, "gap b3");
    bit_(1, 1, 1, 1, "gap b4");
    // len 2, pattern 11 with upper pattern bits set; counter saturates at 3.
    add(0, 0, 1, 8'b1010_0111, 5'd2, 1, 0, 0, 0, "sat load");
    bit_(1, 1, 0, 0, "sat b1");
    bit_(1, 1, 1, 1, "sat b2");
    bit_(1, 1, 1, 2, "sat b3");
    bit_(1, 1, 1, 3, "sat b4");
    bit_(1, 1, 1, 3, "sat b5");
    bit_(1, 1, 1, 3, "sat b6");
    bit_(1, 1, 1, 3, "sat b7");
    bit_(1, 1, 1, 3, "sat b8");

    // Reset with load/valid activity that must be ignored.
    idle_inputs();
    reset = 1'b1;
    in_valid = 1'b1; in = 1'b1;
    cfg_load = 1'b1; cfg_pattern = 8'h03; cfg_len = 5'd2; cfg_overlap = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_cleared("reset state");
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;

    foreach (vecs[i]) begin
      v = vecs[i];
      step(v);
    end

    // Asynchronous reset while out=1 and count=3.
    #2;
    reset = 1'b1;
    in_valid = 1'b1; in = 1'b1;
    cfg_load = 1'b1; cfg_pattern = 8'h03; cfg_len = 5'd2; cfg_overlap = 1'b0;
    #1;
    check_cleared("async reset");
    @(posedge clk);
    #1;
    check_cleared("held reset");
    @(negedge clk);
    idle_inputs();
    reset = 1'b0;

    // Mid-stream reset: 1,1,0 then reset; a lone 1 must not match.
    hbit(1, 1, 0, 0, "rst b1");
    hbit(1, 1, 0, 0, "rst b2");
    v.vld = 1; v.b = 0; v.ld = 1; v.pat = 8'h03; v.len = 5'd9; v.ovl = 0;
    v.eo = 0; v.ec = 0; v.ee = 1; v.tag = "rst b3 badload";
    step(v);
    #2;
    reset = 1'b1;
    #1;
    check_cleared("midstream reset");
    @(negedge clk);
    reset = 1'b0;
    hbit(1, 1, 0, 0, "rst lone1");
    hbit(1, 1, 0, 0, "rst s1");
    hbit(1, 1, 0, 0, "rst s2");
    hbit(1, 0, 0, 0, "rst s3");
    hbit(1, 1, 1, 1, "rst s4");

    // Mid-stream legal reload: same expectations as after reset.
    hbit(1, 1, 0, 1, "rld b1");
    hbit(1, 1, 0, 1, "rld b2");
    hbit(1, 0, 0, 1, "rld b3");
    v.vld = 1; v.b = 1; v.ld = 1; v.pat = 8'b0000_1101; v.len = 5'd4; v.ovl = 1;
    v.eo = 0; v.ec = 0; v.ee = 0; v.tag = "rld load";
    step(v);
    hbit(1, 1, 0, 0, "rld lone1");
    hbit(1, 1, 0, 0, "rld s1");
    hbit(1, 1, 0, 0, "rld s2");
    hbit(1, 0, 0, 0, "rld s3");
    hbit(1, 1, 1, 1, "rld s4");
    hbit(0, 0, 0, 1, "rld idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
